// File: rtl/max_num_driver.sv
// max_num_driver: initiator side of the max_num start/ready handshake.
// It gathers NUM_CLASSES serial scores into a parallel vector, pulses
// mx_start, waits for mx_ready, and then holds the encoded class index
// on a valid/ack output until the consumer takes it.
// Optional feature macro: MAX_NUM_WATCHDOG_EN. When it is defined, WAIT
// gives up after TIMEOUT cycles and reports index 4'hE with an empty one-hot.
//
// Handshakes: a score moves when in_valid && in_ready at a rising clk edge.
// in_ready is high only in COLLECT, and scores are never dropped. A result
// is offered while out_valid is high and retires on the edge where out_ack
// is high. out_valid cannot fall before that edge.
module max_num_driver #(
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_CLASSES = 10,
   parameter int IDX_WIDTH   = 4,
   parameter int TIMEOUT     = 255
) (
   input  logic                                       clk,
   input  logic                                       reset_n,
   input  logic                                       in_valid,
   input  logic [DATA_WIDTH-1:0]                      in_data,
   output logic                                       in_ready,
   output logic [0:NUM_CLASSES-1][DATA_WIDTH-1:0]     mx_matrix,
   output logic                                       mx_start,
   input  logic                                       mx_ready,
   input  logic [NUM_CLASSES-1:0]                     mx_classes,
   output logic                                       out_valid,
   output logic [IDX_WIDTH-1:0]                       out_index,
   output logic [NUM_CLASSES-1:0]                     out_onehot,
   input  logic                                       out_ack,
   output logic                                       busy,
   output logic [1:0]                                 dbg_state
);

   localparam int CNT_W = $clog2(NUM_CLASSES);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CLASSES - 1);

   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_START   = 2'd1,
      S_WAIT    = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   state_t                                r_state;
   state_t                                w_next_state;
   logic [CNT_W-1:0]                      r_cnt;
   logic [0:NUM_CLASSES-1][DATA_WIDTH-1:0] r_matrix;
   logic [IDX_WIDTH-1:0]                  r_out_index;
   logic [NUM_CLASSES-1:0]                r_out_onehot;
   logic                                  w_xfer;
   logic                                  w_capture;
   logic                                  w_timeout;
   logic [IDX_WIDTH-1:0]                  w_enc_index;

   // Scores are signed two's complement. They are stored bit-for-bit, so the
   // signedness only matters inside max_num.
   assign in_ready   = (r_state == S_COLLECT);
   assign w_xfer     = in_valid && in_ready;
   assign mx_start   = (r_state == S_START);
   assign out_valid  = (r_state == S_HOLD);
   assign busy       = !((r_state == S_COLLECT) && (r_cnt == '0));
   assign mx_matrix  = r_matrix;
   assign out_index  = r_out_index;
   assign out_onehot = r_out_onehot;
   assign dbg_state  = r_state;

   // Lowest set bit wins. An empty one-hot encodes as all ones.
   always_comb begin
      w_enc_index = '1;
      for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
         if (mx_classes[i]) w_enc_index = IDX_WIDTH'(i);
      end
   end

`ifdef MAX_NUM_WATCHDOG_EN
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
   logic [7:0] r_wd_cnt;

   // The watchdog counts cycles spent in WAIT. START clears it, so every
   // WAIT visit begins at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                r_wd_cnt <= '0;
      else if (r_state == S_WAIT)  r_wd_cnt <= r_wd_cnt + 8'd1;
      else                         r_wd_cnt <= '0;
   end
`endif

   // Next-state logic. In START, mx_ready is ignored because a stale
   // high left over from the previous result must not be taken.
   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         S_COLLECT: if (w_xfer && (r_cnt == LAST_CNT)) w_next_state = S_START;
         S_START:   w_next_state = S_WAIT;
         S_WAIT: begin
            if (mx_ready) begin
               w_next_state = S_HOLD;
               w_capture    = 1'b1;
            end
`ifdef MAX_NUM_WATCHDOG_EN
            else if (r_wd_cnt == WD_LAST) begin
               w_next_state = S_HOLD;
               w_timeout    = 1'b1;
            end
`endif
         end
         S_HOLD:    if (out_ack) w_next_state = S_COLLECT;
         default:   w_next_state = S_COLLECT;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_COLLECT;
      else          r_state <= w_next_state;
   end

   // Score collection. The vector stays put until the next vector's first
   // score arrives.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt    <= '0;
         r_matrix <= '0;
      end else if (w_xfer) begin
         r_matrix[r_cnt] <= in_data;
         r_cnt           <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CNT_W'(1);
      end
   end

   // Result capture. A normal completion stores the one-hot and its index.
   // A watchdog expiry stores an empty one-hot and index 4'hE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_index  <= '0;
         r_out_onehot <= '0;
      end else if (w_capture) begin
         r_out_index  <= w_enc_index;
         r_out_onehot <= mx_classes;
      end else if (w_timeout) begin
         r_out_index  <= IDX_WIDTH'(14);
         r_out_onehot <= '0;
      end
   end

endmodule

// File: tb/tb_max_num_driver.sv
// tb_max_num_driver: randomized and directed bench for max_num_driver.
// It models max_num at the behavioural level: a signed argmax over the
// scores it sent, with the lowest index winning ties. It computes each
// expected index from the one-hot it hands back.
module tb_max_num_driver;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             in_valid = 1'b0;
   logic [7:0]       in_data = '0;
   logic             in_ready;
   logic [0:9][7:0]  mx_matrix;
   logic             mx_start;
   logic             mx_ready = 1'b0;
   logic [9:0]       mx_classes = '0;
   logic             out_valid;
   logic [3:0]       out_index;
   logic [9:0]       out_onehot;
   logic             out_ack = 1'b0;
   logic             busy;
   logic [1:0]       dbg_state;

   int               n_checks = 0;
   int               n_errors = 0;
   int               start_cnt = 0;
   logic [7:0]       tb_vec [10];

   max_num_driver dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .mx_matrix  (mx_matrix),
      .mx_start   (mx_start),
      .mx_ready   (mx_ready),
      .mx_classes (mx_classes),
      .out_valid  (out_valid),
      .out_index  (out_index),
      .out_onehot (out_onehot),
      .out_ack    (out_ack),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   // Clock generation.
   always #5 clk = ~clk;

   // Count start pulses, sampled away from the active edge.
   always @(negedge clk) if (mx_start) start_cnt++;

   // Stop a hung run.
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference max_num: signed argmax, lowest index on ties.
   function automatic int ref_argmax();
      int best = 0;
      for (int i = 1; i < 10; i++)
         if ($signed(tb_vec[i]) > $signed(tb_vec[best])) best = i;
      return best;
   endfunction

   // Reference encoder: lowest set bit position, or 15 when none is set.
   function automatic logic [3:0] ref_index(input logic [9:0] cls);
      for (int i = 0; i < 10; i++) if (cls[i]) return 4'(i);
      return 4'hF;
   endfunction

   // Streams tb_vec[0..n-1]. mode 0: valid always high, 1: toggling, 2: random.
   task automatic send_scores(input int n, input int mode);
      int i = 0;
      int guard = 0;
      bit ph = 1'b1;
      bit v;
      while (i < n && guard < 400) begin
         @(negedge clk);
         guard++;
         case (mode)
            0:       v = 1'b1;
            1:       begin v = ph; ph = ~ph; end
            default: v = 1'($urandom_range(0, 1));
         endcase
         in_valid = v;
         in_data  = v ? tb_vec[i] : 8'($urandom);
         if (v && in_ready) i++;
      end
      check("send_budget", i, n);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Holds the result for hold_n cycles with in_valid high, then acks.
   task automatic hold_and_ack(input logic [3:0] exp_idx, input logic [9:0] exp_oh, input int hold_n);
      bit bad = 1'b0;
      for (int k = 0; k < hold_n; k++) begin
         @(negedge clk);
         in_valid   = 1'b1;
         in_data    = 8'($urandom);
         mx_ready   = 1'($urandom_range(0, 1));
         mx_classes = 10'($urandom);
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_index !== exp_idx || out_onehot !== exp_oh)
            bad = 1'b1;
      end
      check("hold_stable", bad, 0);
      @(negedge clk);
      out_ack  = 1'b1;
      in_valid = 1'b1;
      mx_ready = 1'b0;
      check("ack_in_ready", in_ready, 0);
      @(negedge clk);
      out_ack  = 1'b0;
      in_valid = 1'b0;
      check("post_ack_valid", out_valid, 0);
      check("post_ack_busy", busy, 0);
      check("post_ack_in_ready", in_ready, 1);
   endtask

   // One full transaction: stream, start, wait lat cycles, deliver, hold, ack.
   task automatic do_vector(input int mode, input int lat, input bit stale,
                            input bit use_cls, input logic [9:0] cls, input int hold_n);
      int          st0 = start_cnt;
      logic [9:0]  exp_cls;
      logic [3:0]  exp_idx;
      bit          bad = 1'b0;
      exp_cls = use_cls ? cls : (10'd1 << ref_argmax());
      exp_idx = ref_index(exp_cls);
      send_scores(10, mode);
      @(negedge clk);
      check("start_pulse", mx_start, 1);
      check("start_in_ready", in_ready, 0);
      for (int i = 0; i < 10; i++) check($sformatf("matrix%0d", i), mx_matrix[i], tb_vec[i]);
      mx_ready   = stale;
      mx_classes = stale ? 10'b0000000001 : 10'b0;
      for (int k = 0; k < lat; k++) begin
         @(negedge clk);
         mx_ready   = 1'b0;
         mx_classes = 10'($urandom);
         if (out_valid !== 1'b0 || mx_start !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
      end
      check("wait_quiet", bad, 0);
      @(negedge clk);
      check("wait_no_valid", out_valid, 0);
      mx_ready   = 1'b1;
      mx_classes = exp_cls;
      @(negedge clk);
      mx_ready   = 1'b0;
      mx_classes = 10'b0;
      check("out_valid", out_valid, 1);
      check("out_index", out_index, exp_idx);
      check("out_onehot", out_onehot, exp_cls);
      check("one_start", start_cnt, st0 + 1);
      hold_and_ack(exp_idx, exp_cls, hold_n);
   endtask

   initial begin
      // Reset and check the reset state.
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_mx_start", mx_start, 0);
      check("rst_busy", busy, 0);
      check("rst_out_index", out_index, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);

      // Ascending scores with in_valid always high: class 9 wins.
      for (int i = 0; i < 10; i++) tb_vec[i] = 8'(i);
      do_vector(0, 0, 1'b0, 1'b0, 10'b0, 2);

      // Descending scores with 0F at index 1, in_valid toggling.
      tb_vec = '{8'h09, 8'h0F, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
      do_vector(1, 1, 1'b0, 1'b0, 10'b0, 1);

      // Stale ready in START with wrong classes; the real answer comes 3 cycles later.
      tb_vec = '{8'h80, 8'h10, 8'hF0, 8'h20, 8'h05, 8'h7E, 8'h7F, 8'h00, 8'hFF, 8'h11};
      do_vector(0, 3, 1'b1, 1'b0, 10'b0, 1);

      // Long hold with in_valid high, then the next vector must fill from 0.
      for (int i = 0; i < 10; i++) tb_vec[i] = 8'($urandom);
      do_vector(2, 2, 1'b0, 1'b0, 10'b0, 20);
      for (int i = 0; i < 10; i++) tb_vec[i] = 8'($urandom);
      do_vector(0, 0, 1'b0, 1'b0, 10'b0, 0);

      // Reset after 5 scores: partial vector aborted.
      begin
         int st0;
         for (int i = 0; i < 10; i++) tb_vec[i] = 8'($urandom_range(1, 255));
         st0 = start_cnt;
         send_scores(5, 0);
         @(negedge clk);
         check("partial_busy", busy, 1);
         #2 reset_n = 1'b0;
         #1;
         check("arst_busy", busy, 0);
         check("arst_out_valid", out_valid, 0);
         check("arst_matrix", mx_matrix, 80'b0);
         check("arst_out_onehot", out_onehot, 0);
         @(negedge clk);
         reset_n = 1'b1;
         repeat (4) @(negedge clk);
         check("arst_no_start", start_cnt, st0);
         for (int i = 0; i < 10; i++) tb_vec[i] = 8'($urandom);
         do_vector(0, 1, 1'b0, 1'b0, 10'b0, 1);
      end

      // Encode edges: empty, multi-hot, and both ends set.
      do_vector(0, 1, 1'b0, 1'b1, 10'b0000000000, 0);
      do_vector(2, 0, 1'b0, 1'b1, 10'b0100101000, 1);
      do_vector(0, 2, 1'b0, 1'b1, 10'b1000000001, 0);

`ifdef MAX_NUM_WATCHDOG_EN
      // Watchdog: max_num never answers.
      begin
         bit early = 1'b0;
         for (int i = 0; i < 10; i++) tb_vec[i] = 8'($urandom);
         send_scores(10, 0);
         @(negedge clk);
         check("wd_start", mx_start, 1);
         mx_ready = 1'b0;
         repeat (255) begin
            @(negedge clk);
            if (out_valid !== 1'b0) early = 1'b1;
         end
         check("wd_early", early, 0);
         @(negedge clk);
         check("wd_valid", out_valid, 1);
         check("wd_index", out_index, 4'hE);
         check("wd_onehot", out_onehot, 0);
         hold_and_ack(4'hE, 10'b0, 1);
      end
`else
      // Without the watchdog, a silent max_num keeps the driver in WAIT.
      for (int i = 0; i < 10; i++) tb_vec[i] = 8'($urandom);
      do_vector(0, 300, 1'b0, 1'b1, 10'b0, 1);
`endif

      // Randomized transactions.
      for (int t = 0; t < 10; t++) begin
         for (int i = 0; i < 10; i++) tb_vec[i] = 8'($urandom);
         do_vector(2, $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'b0, 10'b0,
                   $urandom_range(0, 4));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
